// File: rtl/imem_boot_pkg.sv
// +--------------------------------------------------------------------------+
// | imem_boot_pkg : shared types/constants for the UART imem boot loader     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package imem_boot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        RUN  = 3'd5
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [3:0] BMASK_WORD = 4'hF;

endpackage

`default_nettype wire

// File: rtl/imem_boot_ctrl_packer.sv
// +--------------------------------------------------------------------------+
// | boot_byte_packer : packs little-endian bytes into 32-bit words and keeps |
// | the XOR checksum (accumulator only with IMEM_BOOT_CSUM_EN). Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module boot_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [1:0]  lane,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [31:0] shift;

    // Bytes enter at the top so byte0 ends up in bits [7:0] after four shifts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane       <= 2'd0;
            shift      <= 32'h0;
            word       <= 32'h0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane  <= 2'd0;
                shift <= 32'h0;
            end else if (byte_valid) begin
                shift <= {byte_data, shift[31:8]};
                lane  <= lane + 2'd1;
                if (lane == 2'd3) begin
                    word       <= {byte_data, shift[31:8]};
                    word_valid <= 1'b1;
                end
            end
        end
    end

`ifdef IMEM_BOOT_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'h00;
        end else if (clear) begin
            csum <= 8'h00;
        end else if (byte_valid) begin
            csum <= csum ^ byte_data;
        end
    end
`else
    assign csum = 8'h00;
`endif

endmodule

`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
// +--------------------------------------------------------------------------+
// | imem_boot_ctrl : UART boot-load sequencer in front of imem. Optional     |
// | checksum check via macro IMEM_BOOT_CSUM_EN.  Rev 1.0                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module imem_boot_ctrl
    import imem_boot_pkg::*;
#(
    parameter int         DEPTH   = 2048,
    parameter int         TIMEOUT = 1_000_000,
    parameter logic [7:0] SYNC    = SYNC_BYTE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_boot_req,
    input  logic [31:0] i_cpu_pc,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    output logic        o_cpu_rst,
    output logic        o_busy,
    output logic        o_boot_err
);

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX    = TW'(TIMEOUT - 1);
    localparam logic [16:0]     DEPTH_W = 17'(DEPTH);

    boot_state_e    state, state_next;
    logic [15:0]    index;
    logic [15:0]    count;
    logic [TW-1:0]  tcnt;
    logic           err;

    logic           err_event;
    logic           sync_hit;
    logic           data_byte;
    logic [15:0]    len_full;

    logic [1:0]     lane;
    logic           word_valid;
    logic [31:0]    word;
    logic [7:0]     csum;

    assign len_full = {i_rx_data, count[7:0]};
    assign o_busy   = (state == LEN0) || (state == LEN1) ||
                      (state == DATA) || (state == CSUM);

    boot_byte_packer u_packer (
        .clk        (i_clk),
        .rst        (i_reset),
        .clear      (sync_hit),
        .byte_valid (data_byte),
        .byte_data  (i_rx_data),
        .lane       (lane),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

    always_comb begin
        state_next = state;
        err_event  = 1'b0;
        sync_hit   = 1'b0;
        data_byte  = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_valid && (i_rx_data == SYNC)) begin
                    state_next = LEN0;
                    sync_hit   = 1'b1;
                end
            end
            LEN0: begin
                if (i_rx_valid) state_next = LEN1;
            end
            LEN1: begin
                if (i_rx_valid) begin
                    if ({1'b0, len_full} > DEPTH_W) err_event = 1'b1;
                    else if (len_full == 16'd0)     state_next = CSUM;
                    else                            state_next = DATA;
                end
            end
            DATA: begin
                if (i_rx_valid) begin
                    data_byte = 1'b1;
                    // Index still holds the current word: the previous write
                    // retired at least three cycles ago.
                    if ((lane == 2'd3) && (index == count - 16'd1))
                        state_next = CSUM;
                end
            end
            CSUM: begin
                if (i_rx_valid) begin
`ifdef IMEM_BOOT_CSUM_EN
                    if (i_rx_data == csum) state_next = RUN;
                    else                   err_event  = 1'b1;
`else
                    state_next = RUN;
`endif
                end
            end
            RUN: begin
                if (i_boot_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (o_busy && !i_rx_valid && (tcnt == TMAX)) err_event = 1'b1;
        if (err_event) state_next = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            index <= 16'd0;
            count <= 16'd0;
            tcnt  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (sync_hit)        index <= 16'd0;
            else if (word_valid) index <= index + 16'd1;
            if (i_rx_valid && (state == LEN0)) count[7:0]  <= i_rx_data;
            if (i_rx_valid && (state == LEN1)) count[15:8] <= i_rx_data;
            if (!o_busy || i_rx_valid) tcnt <= '0;
            else if (tcnt != TMAX)     tcnt <= tcnt + 1'b1;
            if (err_event)     err <= 1'b1;
            else if (sync_hit) err <= 1'b0;
        end
    end

    assign o_mem_addr  = (state == RUN) ? {2'b00, i_cpu_pc[31:2]} : {16'h0, index};
    assign o_mem_wdata = word;
    assign o_mem_wren  = word_valid;
    assign o_mem_bmask = word_valid ? BMASK_WORD : 4'h0;
    assign o_cpu_rst   = (state != RUN);
    assign o_boot_err  = err;

    logic unused_bits;
`ifdef IMEM_BOOT_CSUM_EN
    assign unused_bits = ^i_cpu_pc[1:0];
`else
    assign unused_bits = ^{i_cpu_pc[1:0], csum};
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_imem_boot_ctrl : scoreboard bench for imem_boot_ctrl                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        boot_req;
    logic [31:0] cpu_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;
    logic        cpu_rst;
    logic        busy;
    logic        boot_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_wr;
    logic [7:0]  tx_q[$];
    logic [31:0] words[0:3];
    int          compared   = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    imem_boot_ctrl #(
        .DEPTH   (2048),
        .TIMEOUT (100),
        .SYNC    (8'hA5)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .i_boot_req  (boot_req),
        .i_cpu_pc    (cpu_pc),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .o_mem_wren  (mem_wren),
        .o_cpu_rst   (cpu_rst),
        .o_busy      (busy),
        .o_boot_err  (boot_err)
    );

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_write: addr=%h data=%h", mem_addr, mem_wdata);
            end else begin
                exp_wr = sb.pop_front();
                if ({mem_addr, mem_wdata, mem_bmask} !== {exp_wr.addr, exp_wr.data, 4'hF}) begin
                    mismatched++;
                    $display("FAIL mem_write: got addr=%h data=%h bmask=%h, want addr=%h data=%h bmask=f",
                             mem_addr, mem_wdata, mem_bmask, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_q();
        while (tx_q.size() != 0) begin
            @(posedge clk);
            #1;
            rx_valid = 1'b1;
            rx_data  = tx_q.pop_front();
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_frame(input int n, input bit bad);
        logic [15:0] n16;
        logic [7:0]  x;
        logic [7:0]  bt;
        n16 = 16'(n);
        x   = 8'h00;
        tx_q.push_back(8'hA5);
        tx_q.push_back(n16[7:0]);
        tx_q.push_back(n16[15:8]);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                bt = words[i][8*b +: 8];
                tx_q.push_back(bt);
                x = x ^ bt;
            end
            sb.push_back('{addr: 32'(i), data: words[i]});
        end
        tx_q.push_back(x ^ {7'b0, bad});
    endtask

    task automatic leave_run();
        @(posedge clk);
        #1 boot_req = 1'b1;
        @(posedge clk);
        #1 boot_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({cpu_rst, mem_wren, mem_bmask, busy, boot_err} !== 8'b1000_0000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 10000000",
                     {cpu_rst, mem_wren, mem_bmask, busy, boot_err});
        end
        compared++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b100) begin
            mismatched++;
            $display("FAIL idle_after_reset: got %b want 100", {cpu_rst, busy, boot_err});
        end
    endtask

    task automatic test_load();
        words[0] = 32'h0000_0013;
        words[1] = 32'h0010_0093;
        push_frame(2, 1'b0);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL load_writes_pending: got %0d want 0", sb.size());
        end
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b000) begin
            mismatched++;
            $display("FAIL load_run: got %b want 000", {cpu_rst, busy, boot_err});
        end
        cpu_pc = 32'h0000_0008;
        #1;
        compared++;
        if (mem_addr !== 32'h2) begin
            mismatched++;
            $display("FAIL run_addr_8: got %h want 00000002", mem_addr);
        end
        cpu_pc = 32'h1234_567F;
        #1;
        compared++;
        if (mem_addr !== 32'h048D_159F) begin
            mismatched++;
            $display("FAIL run_addr_hi: got %h want 048d159f", mem_addr);
        end
    endtask

    task automatic test_run_ignore();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h00);
        send_q();
        compared++;
        if ({cpu_rst, busy} !== 2'b00) begin
            mismatched++;
            $display("FAIL run_ignores_rx: got %b want 00", {cpu_rst, busy});
        end
    endtask

    task automatic test_boot_req();
        @(posedge clk);
        #1 boot_req = 1'b1;
        #1;
        compared++;
        if (cpu_rst !== 1'b0) begin
            mismatched++;
            $display("FAIL boot_req_early: got %b want 0", cpu_rst);
        end
        @(posedge clk);
        #1 boot_req = 1'b0;
        compared++;
        if ({cpu_rst, busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL boot_req_idle: got %b want 10", {cpu_rst, busy});
        end
    endtask

    task automatic test_noise();
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h0123_4567;
        words[2] = 32'hCAFE_F00D;
        push_frame(3, 1'b0);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL noise_writes_pending: got %0d want 0", sb.size());
        end
        compared++;
        if ({cpu_rst, boot_err} !== 2'b00) begin
            mismatched++;
            $display("FAIL noise_run: got %b want 00", {cpu_rst, boot_err});
        end
        leave_run();
    endtask

    task automatic test_depth_err();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h01);
        tx_q.push_back(8'h08);
        send_q();
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b101) begin
            mismatched++;
            $display("FAIL depth_err: got %b want 101", {cpu_rst, busy, boot_err});
        end
        tx_q.push_back(8'h13);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({busy, boot_err} !== 2'b01) begin
            mismatched++;
            $display("FAIL depth_err_sticky: got %b want 01", {busy, boot_err});
        end
    endtask

    task automatic test_err_clear();
        tx_q.push_back(8'hA5);
        send_q();
        compared++;
        if ({busy, boot_err} !== 2'b10) begin
            mismatched++;
            $display("FAIL err_clear_on_sync: got %b want 10", {busy, boot_err});
        end
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_q();
        compared++;
        if (cpu_rst !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_after_clear_run: got %b want 0", cpu_rst);
        end
        leave_run();
    endtask

    task automatic test_bad_csum();
        words[0] = 32'h0BAD_F00D;
        push_frame(1, 1'b1);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (sb.size() !== 0) begin
            mismatched++;
            $display("FAIL bad_csum_writes_pending: got %0d want 0", sb.size());
        end
`ifdef IMEM_BOOT_CSUM_EN
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b101) begin
            mismatched++;
            $display("FAIL bad_csum_err: got %b want 101", {cpu_rst, busy, boot_err});
        end
`else
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b000) begin
            mismatched++;
            $display("FAIL csum_ignored_run: got %b want 000", {cpu_rst, busy, boot_err});
        end
        leave_run();
`endif
    endtask

    task automatic test_timeout();
        // Count 0x0800 equals DEPTH and must be accepted.
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h08);
        tx_q.push_back(8'h13);
        tx_q.push_back(8'h37);
        send_q();
        compared++;
        if ({busy, boot_err} !== 2'b10) begin
            mismatched++;
            $display("FAIL depth_max_accepted: got %b want 10", {busy, boot_err});
        end
        repeat (99) @(posedge clk);
        #1;
        compared++;
        if ({busy, boot_err} !== 2'b10) begin
            mismatched++;
            $display("FAIL timeout_early: got %b want 10", {busy, boot_err});
        end
        @(posedge clk);
        #1;
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b101) begin
            mismatched++;
            $display("FAIL timeout_err: got %b want 101", {cpu_rst, busy, boot_err});
        end
    endtask

    task automatic test_zero();
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        tx_q.push_back(8'h00);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({cpu_rst, busy, boot_err} !== 3'b000) begin
            mismatched++;
            $display("FAIL zero_count_run: got %b want 000", {cpu_rst, busy, boot_err});
        end
        leave_run();
    endtask

    task automatic test_reset_mid();
        words[0] = 32'h1122_3344;
        words[1] = 32'h5566_7788;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h02);
        tx_q.push_back(8'h00);
        for (int b = 0; b < 4; b++) tx_q.push_back(words[0][8*b +: 8]);
        tx_q.push_back(8'h88);
        tx_q.push_back(8'h77);
        sb.push_back('{addr: 32'h0, data: words[0]});
        send_q();
        #3 rst = 1'b1;
        #1;
        compared++;
        if ({cpu_rst, mem_wren, mem_bmask, busy, boot_err} !== 8'b1000_0000) begin
            mismatched++;
            $display("FAIL mid_reset_flags: got %b want 10000000",
                     {cpu_rst, mem_wren, mem_bmask, busy, boot_err});
        end
        compared++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            mismatched++;
            $display("FAIL mid_reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h0000_00A5;
        push_frame(2, 1'b0);
        send_q();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({sb.size() == 0, cpu_rst} !== 2'b10) begin
            mismatched++;
            $display("FAIL reload_after_reset: got empty/cpu_rst=%b want 10",
                     {sb.size() == 0, cpu_rst});
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        boot_req = 1'b0;
        cpu_pc   = 32'h0;
        test_reset();
        test_load();
        test_run_ignore();
        test_boot_req();
        test_noise();
        test_depth_err();
        test_err_clear();
        test_bad_csum();
        test_timeout();
        test_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
